// File: rtl/ram1_uart_ctrl.sv
// ram1_uart_ctrl: MEM-stage sequencer for the shared Ram1 SRAM/UART bus
module ram1_uart_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);
  typedef enum logic [3:0] {IDLE, SR1, SR2, SW1, SW2, SW3, UR1, UR2, UR3, UW1, UW2, UW3, DONE} state_t;
  state_t state;
  logic [15:0] addr_q, wdata_q;
  logic sram, drive;
  // sequence each access; rdata_o only changes when a read completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE:
          if (req_write_i)
            state <= addr_i == UART_DATA_ADDR ? UW1 : addr_i == UART_STAT_ADDR ? DONE : SW1;
          else if (req_read_i) begin
            if (addr_i == UART_STAT_ADDR) rdata_o <= {14'b0, data_ready, tbre & tsre};
            state <= addr_i == UART_DATA_ADDR ? UR1 : addr_i == UART_STAT_ADDR ? DONE : SR1;
          end
        SR1: state <= SR2;
        SR2: begin
          rdata_o <= Ram1Data;
          state   <= DONE;
        end
        SW1: state <= SW2;
        SW2: state <= SW3;
        SW3: state <= DONE;
        UW1: state <= UW2;
        UW2: state <= UW3;
        UW3: if (tbre && tsre) state <= DONE;
        UR1: if (data_ready) state <= UR2;
        UR2: state <= UR3;
        UR3: begin
          rdata_o <= Ram1Data;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // capture the request operands at acceptance; data path needs no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && (req_read_i || req_write_i)) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end
  assign sram     = state inside {SR1, SR2, SW1, SW2, SW3};
  assign drive    = state inside {SW1, SW2, SW3, UW1, UW2, UW3};
  assign Ram1EN   = !sram;
  assign Ram1OE   = !(state inside {SR1, SR2});
  assign Ram1WE   = state != SW2;
  assign wrn      = state != UW2;
  assign rdn      = !(state inside {UR2, UR3});
  assign Ram1Addr = sram ? {2'b00, addr_q} : 18'd0;
  assign Ram1Data = drive ? wdata_q : 16'hzzzz;
  assign done_o   = state == DONE;
  assign busy_o   = (state == IDLE && (req_read_i || req_write_i)) || (state != IDLE && state != DONE);
endmodule

// File: tb/tb_ram1_uart_ctrl.sv
// tb_ram1_uart_ctrl: directed checks of the Ram1 SRAM/UART sequencer
module tb_ram1_uart_ctrl;
  logic clk = 0, rst = 0;
  logic req_read_i = 0, req_write_i = 0;
  logic [15:0] addr_i = 0, wdata_i = 0;
  logic [15:0] rdata_o;
  logic busy_o, done_o;
  logic [17:0] Ram1Addr;
  wire  [15:0] Ram1Data;
  logic Ram1OE, Ram1WE, Ram1EN, rdn, wrn;
  logic data_ready = 0, tbre = 1, tsre = 1;
  logic [15:0] mem [0:255];
  int total = 0, bad = 0, lat, bsy;
  int we_cnt, wrn_cnt, rdn_cnt, en_cnt, strobe_cnt, bus41_cnt, bad_bus;
  logic mon_bus = 0;

  ram1_uart_ctrl dut (
    .clk(clk), .rst(rst), .req_read_i(req_read_i), .req_write_i(req_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o),
    .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN),
    .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  always #5 clk = ~clk;

  // SRAM and UART receive-register models on the shared bus
  assign Ram1Data = (!Ram1EN && !Ram1OE) ? mem[Ram1Addr[7:0]] : 16'hzzzz;
  assign Ram1Data = !rdn ? 16'h0037 : 16'hzzzz;
  always @(posedge Ram1WE) if (Ram1EN == 1'b0) mem[Ram1Addr[7:0]] <= Ram1Data;

  function automatic bit rel(input logic [15:0] v);
    return v === 16'hzzzz || v === 16'h0000;
  endfunction

  // per-cycle strobe and bus activity counters
  always @(posedge clk) begin
    if (Ram1WE === 1'b0) we_cnt++;
    if (wrn === 1'b0) wrn_cnt++;
    if (rdn === 1'b0) rdn_cnt++;
    if (Ram1EN === 1'b0) en_cnt++;
    if (!(Ram1EN && Ram1OE && Ram1WE && rdn && wrn)) strobe_cnt++;
    if (Ram1Data === 16'h0041) bus41_cnt++;
    if (mon_bus && (rdn === 1'b0 ? Ram1Data !== 16'h0037 : !rel(Ram1Data))) bad_bus++;
  end

  task automatic clr();
    we_cnt = 0; wrn_cnt = 0; rdn_cnt = 0; en_cnt = 0; strobe_cnt = 0; bus41_cnt = 0; bad_bus = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // issue one request from a negedge and wait (bounded) for done_o
  task automatic run(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                     output int l, output int b);
    req_read_i = rd; req_write_i = wr; addr_i = a; wdata_i = d;
    b = 0;
    #1 if (busy_o) b++;
    @(negedge clk);
    req_read_i = 0; req_write_i = 0;
    l = 1;
    while (done_o !== 1'b1 && l < 100) begin
      if (busy_o) b++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", Ram1WE, 1);
    chk("rst_en_oe", {Ram1EN, Ram1OE}, 2'b11);
    chk("rst_rdn_wrn", {rdn, wrn}, 2'b11);
    chk("rst_addr", Ram1Addr, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_done_busy", {done_o, busy_o}, 0);
    rst = 1;
    @(negedge clk);
    // SRAM write, stepped cycle by cycle
    clr();
    req_write_i = 1; addr_i = 16'h0010; wdata_i = 16'hA5C3;
    #1 chk("sw_busy_accept", busy_o, 1);
    @(negedge clk);
    req_write_i = 0;
    chk("sw1_addr", Ram1Addr, 18'h00010);
    chk("sw1_strobes", {Ram1EN, Ram1OE, Ram1WE}, 3'b011);
    chk("sw1_bus", Ram1Data, 16'hA5C3);
    @(negedge clk);
    chk("sw2_we", {Ram1WE, Ram1Addr}, {1'b0, 18'h00010});
    @(negedge clk);
    chk("sw3_we", Ram1WE, 1);
    chk("sw3_bus", Ram1Data, 16'hA5C3);
    @(negedge clk);
    chk("sw_done", {done_o, busy_o, Ram1EN}, 3'b101);
    @(negedge clk);
    chk("sw_done_width", done_o, 0);
    chk("sw_we_cnt", we_cnt, 1);
    // SRAM read back
    run(1, 0, 16'h0010, 16'hFFFF, lat, bsy);
    chk("sr_lat", lat, 3);
    chk("sr_stall", bsy, 3);
    chk("sr_rdata", rdata_o, 16'hA5C3);
    @(negedge clk);
    chk("sr_done_width", done_o, 0);
    // UART write, transmitter busy for 5 cycles after UW3 entry
    tbre = 0; tsre = 1;
    clr();
    fork
      begin
        @(posedge wrn);
        repeat (5) @(posedge clk);
        @(negedge clk) tbre = 1;
      end
    join_none
    run(0, 1, 16'hBF00, 16'h0041, lat, bsy);
    chk("uw_lat", lat, 9);
    chk("uw_wrn_cnt", wrn_cnt, 1);
    chk("uw_bus_cycles", bus41_cnt, 8);
    chk("uw_en_cnt", en_cnt, 0);
    @(negedge clk);
    // UART read, data_ready arrives after 4 cycles in UR1
    data_ready = 0;
    clr();
    mon_bus = 1;
    fork
      begin
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk) data_ready = 1;
      end
    join_none
    run(1, 0, 16'hBF00, 16'hFFFF, lat, bsy);
    mon_bus = 0;
    chk("ur_lat", lat, 8);
    chk("ur_rdata", rdata_o, 16'h0037);
    chk("ur_rdn_cnt", rdn_cnt, 2);
    chk("ur_bus", bad_bus, 0);
    chk("ur_en_cnt", en_cnt, 0);
    @(negedge clk);
    // write to the read-only status register: no bus activity, rdata kept
    clr();
    run(0, 1, 16'hBF01, 16'hAAAA, lat, bsy);
    chk("stw_lat", lat, 1);
    chk("stw_rdata_kept", rdata_o, 16'h0037);
    chk("stw_strobes", strobe_cnt, 0);
    @(negedge clk);
    // status read
    data_ready = 1; tbre = 1; tsre = 0;
    clr();
    run(1, 0, 16'hBF01, 16'hFFFF, lat, bsy);
    chk("st_lat", lat, 1);
    chk("st_rdata", rdata_o, 16'h0002);
    chk("st_strobes", strobe_cnt, 0);
    tsre = 1;
    @(negedge clk);
    // reset in SW2
    req_write_i = 1; addr_i = 16'h0030; wdata_i = 16'hBEEF;
    @(negedge clk);
    req_write_i = 0;
    @(negedge clk);
    chk("rs_sw2_we", Ram1WE, 0);
    #2 rst = 0;
    #1 chk("rs_we", Ram1WE, 1);
    chk("rs_bus_released", rel(Ram1Data), 1);
    chk("rs_rdata", rdata_o, 0);
    chk("rs_idle", {done_o, busy_o, Ram1EN}, 3'b001);
    req_read_i = 1;
    #1 chk("rs_busy_req", busy_o, 1);
    req_read_i = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    // simultaneous requests: the write wins
    run(1, 1, 16'h0020, 16'h1234, lat, bsy);
    chk("sim_lat", lat, 4);
    chk("sim_rdata_kept", rdata_o, 0);
    @(negedge clk);
    run(1, 0, 16'h0020, 16'hFFFF, lat, bsy);
    chk("sim_rd_lat", lat, 3);
    chk("sim_rdata", rdata_o, 16'h1234);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
